// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: per-channel source streams and the shared sink stream of stream_mux_rr
interface stream_mux_rr_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = $clog2(NUM_CH);
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_last;
  logic [NUM_CH-1:0] in_ready;
  logic [DATA_W-1:0] out_data;
  logic out_last;
  logic [SEL_W-1:0] out_sel;
  logic out_valid;
  logic out_ready;
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_sel, out_valid
  );
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_sel, out_valid
  );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: packet-atomic N:1 stream mux with round-robin or fixed-select arbitration
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic [$clog2(NUM_CH)-1:0] sel_i,
  stream_mux_rr_if.slave s,
  output logic busy
);
  localparam int SEL_W = $clog2(NUM_CH);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state_q;
  logic [SEL_W-1:0] grant_q;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] out_sel_q;
  logic [DATA_W-1:0] out_data_q;
  logic out_last_q;
  logic out_valid_q;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] rr_idx;
  logic rr_hit;
  logic sel_ok;
  logic arb_hit;
  logic [SEL_W-1:0] arb_idx;
  logic take;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_data[g] = s.in_data[g*DATA_W +: DATA_W];
  end
  // round-robin search: walk from farthest to nearest so the channel just above rr_ptr wins
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = SEL_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (s.in_valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end
  assign sel_ok = int'(sel_i) < NUM_CH;
  assign arb_hit = mode ? (sel_ok && s.in_valid[sel_i]) : rr_hit;
  assign arb_idx = mode ? sel_i : rr_idx;
  assign s.in_ready = (state_q == LOCK && (!out_valid_q || s.out_ready)) ? NUM_CH'(1) << grant_q : '0;
  assign take = |(s.in_ready & s.in_valid);
  // arbitration, packet lock until last beat, and the registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= SEL_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_sel_q <= '0;
    end else begin
      if (take) begin
        out_data_q <= ch_data[grant_q];
        out_last_q <= s.in_last[grant_q];
        out_sel_q <= grant_q;
        out_valid_q <= 1'b1;
      end else if (s.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (state_q == IDLE && arb_hit) begin
        state_q <= LOCK;
        grant_q <= arb_idx;
      end
      if (state_q == LOCK && take && s.in_last[grant_q]) begin
        state_q <= IDLE;
        rr_ptr_q <= grant_q;
      end
    end
  end
  assign s.out_data = out_data_q;
  assign s.out_last = out_last_q;
  assign s.out_sel = out_sel_q;
  assign s.out_valid = out_valid_q;
  assign busy = state_q == LOCK;
endmodule
